// File: rtl/blk_mem_arb_pkg.sv
// Shared types for the lookup-table RAM read arbiter: requester IDs and the
// {valid, id} entry carried alongside reads in flight.
package blk_mem_arb_pkg;

  localparam logic REQ_0 = 1'b0;
  localparam logic REQ_1 = 1'b1;

  typedef struct packed {
    logic vld;
    logic id;
  } rsp_ent_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; grants are combinational from the eligible
// inputs, and the preferred requester flips to the other side after each grant.
module rr_arb2
  import blk_mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic elig_0,
  input  logic elig_1,
  output logic gnt_0,
  output logic gnt_1
);

  logic prio;

  always_comb begin
    gnt_0 = elig_0 & (~elig_1 | (prio == REQ_0));
    gnt_1 = elig_1 & ~gnt_0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= REQ_0;
    end else if (gnt_0) begin
      prio <= REQ_1;
    end else if (gnt_1) begin
      prio <= REQ_0;
    end
  end

endmodule

// File: rtl/blk_mem_rd_arb.sv
// Shares RAM read port B between two requesters, gates config writes onto port A.
// Response appears RD_LAT cycles after the grant; no response backpressure, writes never stall.
module blk_mem_rd_arb
  import blk_mem_arb_pkg::*;
#(
  parameter int ADDR_BITS = 4,
  parameter int DATA_BITS = 625,
  parameter int RD_LAT    = 1,
  parameter int CNT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] rd_addr_0,
  input  logic [ADDR_BITS-1:0] rd_addr_1,
  input  logic                 rd_valid_0,
  input  logic                 rd_valid_1,
  output logic                 rd_ready_0,
  output logic                 rd_ready_1,
  output logic [DATA_BITS-1:0] rsp_data,
  output logic                 rsp_id,
  output logic                 rsp_valid,
  input  logic [ADDR_BITS-1:0] cfg_addr,
  input  logic [DATA_BITS-1:0] cfg_data,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  output logic [ADDR_BITS-1:0] ram_addra,
  output logic [DATA_BITS-1:0] ram_dina,
  output logic                 ram_ena,
  output logic                 ram_wea,
  output logic [ADDR_BITS-1:0] ram_addrb,
  output logic                 ram_enb,
  input  logic [DATA_BITS-1:0] ram_doutb,
  output logic [CNT_BITS-1:0]  stall_cnt
);

  logic                 cfg_we;
  logic                 hit_0, hit_1;
  logic                 elig_0, elig_1;
  logic                 gnt_0, gnt_1;
  logic                 blocked;
  logic [ADDR_BITS-1:0] addrb_q;
  rsp_ent_t             pipe [RD_LAT];

  assign cfg_we    = cfg_valid & ~rst;
  assign cfg_ready = ~rst;
  assign ram_ena   = cfg_we;
  assign ram_wea   = cfg_we;
  assign ram_addra = cfg_addr;
  assign ram_dina  = cfg_data;

  // A read colliding with this cycle's write waits one cycle so it sees the new data.
  assign hit_0   = cfg_we && (cfg_addr == rd_addr_0);
  assign hit_1   = cfg_we && (cfg_addr == rd_addr_1);
  assign elig_0  = rd_valid_0 & ~rst & ~hit_0;
  assign elig_1  = rd_valid_1 & ~rst & ~hit_1;
  assign blocked = (rd_valid_0 & hit_0) | (rd_valid_1 & hit_1);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .elig_0 (elig_0),
    .elig_1 (elig_1),
    .gnt_0  (gnt_0),
    .gnt_1  (gnt_1)
  );

  assign rd_ready_0 = gnt_0;
  assign rd_ready_1 = gnt_1;
  assign ram_enb    = gnt_0 | gnt_1;

  always_comb begin
    ram_addrb = addrb_q;
    if (gnt_1) begin
      ram_addrb = rd_addr_1;
    end else if (gnt_0) begin
      ram_addrb = rd_addr_0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addrb_q <= '0;
    end else if (ram_enb) begin
      addrb_q <= ram_addrb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0].vld <= ram_enb;
      pipe[0].id  <= gnt_1 ? REQ_1 : REQ_0;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign rsp_valid = pipe[RD_LAT-1].vld;
  assign rsp_id    = pipe[RD_LAT-1].id;
  assign rsp_data  = ram_doutb;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (blocked && (stall_cnt != {CNT_BITS{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_blk_mem_rd_arb.sv
// Directed bench: dut_a uses RD_LAT=1/CNT_BITS=16, dut_b RD_LAT=2/CNT_BITS=4;
// both see the same stimulus and each drives its own behavioural RAM.
module tb_blk_mem_rd_arb;

  localparam int AW = 4;
  localparam int DW = 625;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rd_addr_0, rd_addr_1, cfg_addr;
  logic          rd_valid_0, rd_valid_1, cfg_valid;
  logic [DW-1:0] cfg_data;

  logic          rdy0_a, rdy1_a, rspv_a, rspid_a, cfgr_a, ena_a, wea_a, enb_a;
  logic [DW-1:0] rspd_a, dina_a, doutb_a;
  logic [AW-1:0] addra_a, addrb_a;
  logic [15:0]   stall_a;

  logic          rdy0_b, rdy1_b, rspv_b, rspid_b, cfgr_b, ena_b, wea_b, enb_b;
  logic [DW-1:0] rspd_b, dina_b, doutb_b;
  logic [AW-1:0] addra_b, addrb_b;
  logic [3:0]    stall_b;

  logic [DW-1:0] mem_a [16];
  logic [DW-1:0] mem_b [16];
  logic [DW-1:0] q1_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  blk_mem_rd_arb #(.ADDR_BITS(AW), .DATA_BITS(DW), .RD_LAT(1), .CNT_BITS(16)) dut_a (
    .clk(clk), .rst(rst),
    .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1),
    .rd_valid_0(rd_valid_0), .rd_valid_1(rd_valid_1),
    .rd_ready_0(rdy0_a), .rd_ready_1(rdy1_a),
    .rsp_data(rspd_a), .rsp_id(rspid_a), .rsp_valid(rspv_a),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfgr_a),
    .ram_addra(addra_a), .ram_dina(dina_a), .ram_ena(ena_a), .ram_wea(wea_a),
    .ram_addrb(addrb_a), .ram_enb(enb_a), .ram_doutb(doutb_a),
    .stall_cnt(stall_a)
  );

  blk_mem_rd_arb #(.ADDR_BITS(AW), .DATA_BITS(DW), .RD_LAT(2), .CNT_BITS(4)) dut_b (
    .clk(clk), .rst(rst),
    .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1),
    .rd_valid_0(rd_valid_0), .rd_valid_1(rd_valid_1),
    .rd_ready_0(rdy0_b), .rd_ready_1(rdy1_b),
    .rsp_data(rspd_b), .rsp_id(rspid_b), .rsp_valid(rspv_b),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfgr_b),
    .ram_addra(addra_b), .ram_dina(dina_b), .ram_ena(ena_b), .ram_wea(wea_b),
    .ram_addrb(addrb_b), .ram_enb(enb_b), .ram_doutb(doutb_b),
    .stall_cnt(stall_b)
  );

  // RAM models: one-cycle and two-cycle read latency.
  always @(posedge clk) begin
    if (ena_a && wea_a) mem_a[addra_a] <= dina_a;
    if (enb_a) doutb_a <= mem_a[addrb_a];
    if (ena_b && wea_b) mem_b[addra_b] <= dina_b;
    if (enb_b) q1_b <= mem_b[addrb_b];
    doutb_b <= q1_b;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rd_valid_0 = 1'b1; rd_valid_1 = 1'b0; rd_addr_0 = 4'd0; rd_addr_1 = 4'd0;
    cfg_valid = 1'b1; cfg_addr = 4'd0; cfg_data = '0;
    step(); step();
    checks++; if (rspv_a !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rspv_a); end
    checks++; if (rspid_a !== 1'b0) begin errors++; $display("FAIL rst_rsp_id: got %b want 0", rspid_a); end
    checks++; if (rdy0_a !== 1'b0) begin errors++; $display("FAIL rst_rd_ready_0: got %b want 0", rdy0_a); end
    checks++; if (enb_a !== 1'b0) begin errors++; $display("FAIL rst_ram_enb: got %b want 0", enb_a); end
    checks++; if ({ena_a, wea_a} !== 2'b00) begin errors++; $display("FAIL rst_ram_ena_wea: got %b want 00", {ena_a, wea_a}); end
    checks++; if (cfgr_a !== 1'b0) begin errors++; $display("FAIL rst_cfg_ready: got %b want 0", cfgr_a); end
    checks++; if (stall_a !== 16'd0) begin errors++; $display("FAIL rst_stall_cnt: got %0d want 0", stall_a); end
    checks++; if (addrb_a !== 4'd0) begin errors++; $display("FAIL rst_ram_addrb: got %0d want 0", addrb_a); end
    rst = 1'b0; rd_valid_0 = 1'b0; cfg_valid = 1'b0;
    #1;
    checks++; if (cfgr_a !== 1'b1) begin errors++; $display("FAIL cfg_ready_after_rst: got %b want 1", cfgr_a); end
    step();
  endtask

  task automatic cfg_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
    #1;
    checks++;
    if ({ena_a, wea_a, addra_a, dina_a} !== {2'b11, a, d}) begin
      errors++; $display("FAIL cfg_port_a: got en=%b we=%b addr=%0d data=%0h want addr=%0d data=%0h",
                         ena_a, wea_a, addra_a, dina_a, a, d);
    end
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic test_single_read();
    rd_valid_0 = 1'b1; rd_addr_0 = 4'd3;
    #1;
    checks++; if ({rdy0_a, rdy1_a} !== 2'b10) begin errors++; $display("FAIL single_ready: got %b want 10", {rdy0_a, rdy1_a}); end
    checks++; if ({enb_a, addrb_a} !== {1'b1, 4'd3}) begin errors++; $display("FAIL single_portb: got %b/%0d want 1/3", enb_a, addrb_a); end
    step();
    rd_valid_0 = 1'b0;
    checks++; if ({rspv_a, rspid_a} !== 2'b10) begin errors++; $display("FAIL single_rsp: got v=%b id=%b want v=1 id=0", rspv_a, rspid_a); end
    checks++; if (rspd_a !== 625'h1AB) begin errors++; $display("FAIL single_data: got %0h want 1ab", rspd_a); end
    step();
    checks++; if (rspv_a !== 1'b0) begin errors++; $display("FAIL single_no_extra: got %b want 0", rspv_a); end
    // Requester 1 alone returns prio to 0 and exercises id=1.
    rd_valid_1 = 1'b1; rd_addr_1 = 4'd2;
    #1;
    checks++; if ({rdy0_a, rdy1_a} !== 2'b01) begin errors++; $display("FAIL single1_ready: got %b want 01", {rdy0_a, rdy1_a}); end
    step();
    rd_valid_1 = 1'b0;
    checks++; if ({rspv_a, rspid_a, rspd_a} !== {2'b11, 625'h222}) begin
      errors++; $display("FAIL single1_rsp: got v=%b id=%b data=%0h want 1/1/222", rspv_a, rspid_a, rspd_a);
    end
    step();
  endtask

  task automatic test_fairness();
    logic [DW-1:0] exp_d;
    rd_valid_0 = 1'b1; rd_addr_0 = 4'd1;
    rd_valid_1 = 1'b1; rd_addr_1 = 4'd2;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if ({rdy0_a, rdy1_a} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL fair_grant[%0d]: got %b want %s", k, {rdy0_a, rdy1_a}, (k % 2 == 0) ? "10" : "01");
      end
      step();
      exp_d = (k % 2 == 0) ? 625'h111 : 625'h222;
      checks++;
      if ({rspv_a, rspid_a, rspd_a} !== {1'b1, (k % 2 == 1), exp_d}) begin
        errors++; $display("FAIL fair_rsp[%0d]: got v=%b id=%b data=%0h want 1/%0d/%0h", k, rspv_a, rspid_a, rspd_a, k % 2, exp_d);
      end
    end
    rd_valid_0 = 1'b0; rd_valid_1 = 1'b0;
    step();
    checks++; if (rspv_a !== 1'b0) begin errors++; $display("FAIL fair_idle: got %b want 0", rspv_a); end
  endtask

  task automatic test_hazard();
    cfg_valid = 1'b1; cfg_addr = 4'd5; cfg_data = 625'h77;
    rd_valid_1 = 1'b1; rd_addr_1 = 4'd5;
    #1;
    checks++; if ({rdy1_a, enb_a} !== 2'b00) begin errors++; $display("FAIL hazard_block: got rdy=%b enb=%b want 0/0", rdy1_a, enb_a); end
    step();
    cfg_valid = 1'b0;
    #1;
    checks++; if (rdy1_a !== 1'b1) begin errors++; $display("FAIL hazard_retry: got %b want 1", rdy1_a); end
    step();
    rd_valid_1 = 1'b0;
    checks++; if ({rspv_a, rspid_a, rspd_a} !== {2'b11, 625'h77}) begin
      errors++; $display("FAIL hazard_rsp: got v=%b id=%b data=%0h want 1/1/77", rspv_a, rspid_a, rspd_a);
    end
    checks++; if (stall_a !== 16'd1) begin errors++; $display("FAIL hazard_stall: got %0d want 1", stall_a); end
    step();
  endtask

  task automatic test_diff_addr();
    cfg_valid = 1'b1; cfg_addr = 4'd4; cfg_data = 625'h44;
    rd_valid_0 = 1'b1; rd_addr_0 = 4'd6;
    #1;
    checks++; if (rdy0_a !== 1'b1) begin errors++; $display("FAIL diff_grant: got %b want 1", rdy0_a); end
    step();
    cfg_valid = 1'b0; rd_valid_0 = 1'b0;
    checks++; if ({rspv_a, rspd_a} !== {1'b1, 625'h66}) begin errors++; $display("FAIL diff_rsp: got v=%b data=%0h want 1/66", rspv_a, rspd_a); end
    checks++; if (stall_a !== 16'd1) begin errors++; $display("FAIL diff_stall: got %0d want 1", stall_a); end
    // Write-then-read of addr 4 sees the new value.
    rd_valid_1 = 1'b1; rd_addr_1 = 4'd4;
    step();
    rd_valid_1 = 1'b0;
    checks++; if ({rspv_a, rspid_a, rspd_a} !== {2'b11, 625'h44}) begin
      errors++; $display("FAIL raw_rsp: got v=%b id=%b data=%0h want 1/1/44", rspv_a, rspid_a, rspd_a);
    end
    step();
  endtask

  task automatic test_reset_midflight();
    rd_valid_1 = 1'b1; rd_addr_1 = 4'd2;
    step();
    rd_valid_1 = 1'b0; rd_valid_0 = 1'b1; rd_addr_0 = 4'd1;
    step();
    rd_valid_0 = 1'b0;
    checks++; if ({rspv_b, rspid_b, rspd_b} !== {2'b11, 625'h222}) begin
      errors++; $display("FAIL lat2_rsp: got v=%b id=%b data=%0h want 1/1/222", rspv_b, rspid_b, rspd_b);
    end
    rst = 1'b1;
    step();
    checks++; if (rspv_b !== 1'b0) begin errors++; $display("FAIL midrst_drop: got %b want 0", rspv_b); end
    rst = 1'b0;
    step();
    checks++; if (rspv_b !== 1'b0) begin errors++; $display("FAIL midrst_drop2: got %b want 0", rspv_b); end
    rd_valid_0 = 1'b1; rd_addr_0 = 4'd1;
    rd_valid_1 = 1'b1; rd_addr_1 = 4'd2;
    #1;
    checks++; if ({rdy0_b, rdy1_b} !== 2'b10) begin errors++; $display("FAIL midrst_prio: got %b want 10", {rdy0_b, rdy1_b}); end
    step();
    rd_valid_0 = 1'b0; rd_valid_1 = 1'b0;
    checks++; if (rspv_b !== 1'b0) begin errors++; $display("FAIL midrst_early: got %b want 0", rspv_b); end
    step();
    checks++; if ({rspv_b, rspid_b, rspd_b} !== {2'b10, 625'h111}) begin
      errors++; $display("FAIL midrst_next: got v=%b id=%b data=%0h want 1/0/111", rspv_b, rspid_b, rspd_b);
    end
    step();
  endtask

  task automatic test_saturation();
    cfg_valid = 1'b1; cfg_addr = 4'd7; cfg_data = 625'h7;
    rd_valid_0 = 1'b1; rd_addr_0 = 4'd7;
    #1;
    checks++; if (rdy0_a !== 1'b0) begin errors++; $display("FAIL sat_block: got %b want 0", rdy0_a); end
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) begin
        checks++; if (stall_b !== 4'd14) begin errors++; $display("FAIL sat_count14: got %0d want 14", stall_b); end
      end
    end
    checks++; if (stall_b !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d want 15", stall_b); end
    checks++; if (stall_a !== 16'd20) begin errors++; $display("FAIL sat_wide: got %0d want 20", stall_a); end
    cfg_valid = 1'b0;
    #1;
    checks++; if (rdy0_a !== 1'b1) begin errors++; $display("FAIL sat_release: got %b want 1", rdy0_a); end
    step();
    rd_valid_0 = 1'b0;
    checks++; if ({rspv_a, rspd_a} !== {1'b1, 625'h7}) begin errors++; $display("FAIL sat_rsp: got v=%b data=%0h want 1/7", rspv_a, rspd_a); end
    checks++; if (stall_b !== 4'd15) begin errors++; $display("FAIL sat_after: got %0d want 15", stall_b); end
    step();
  endtask

  initial begin
    test_reset();
    cfg_write(4'd3, 625'h1AB);
    cfg_write(4'd1, 625'h111);
    cfg_write(4'd2, 625'h222);
    cfg_write(4'd6, 625'h66);
    step();
    test_single_read();
    test_fairness();
    test_hazard();
    test_diff_addr();
    test_reset_midflight();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
